jtdd_irqctl: RTL and testbench
==============================

JTDD_IRQCTL -- requirements
Module: jtdd_irqctl

Interface
REQ-001 SHALL have parameter N, default 3: interrupt channel count, legal range 1..8.
REQ-002 SHALL have parameter EDGE, default {N{1'b1}}: per-channel mode, 1=edge-triggered, 0=level-sensitive.
REQ-003 SHALL have parameter POL, default {N{1'b1}}: per-channel active sense, 1=rising/high, 0=falling/low.
REQ-004 SHALL have parameter MASK_RST, default {N{1'b1}}: mask register value after reset.
REQ-005 SHALL have parameter AUTOCLR, default {N{1'b0}}: per-channel clear of pending on irq_ack.
REQ-006 SHALL have parameter PAUSE_CH, default N-1: channel gated by pause.
REQ-007 clk  in  1  system clock; the only clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 cen  in  1  CPU bus clock enable; qualifies register writes only.
REQ-010 sig  in  N  raw interrupt sources.
REQ-011 pause  in  1  when high, channel PAUSE_CH cannot set pending.
REQ-012 cs  in  1  register-block select.
REQ-013 we  in  1  write strobe, valid with cs & cen.
REQ-014 addr  in  2  register address.
REQ-015 din  in  8  CPU write data.
REQ-016 dout  out  8  register read data, combinational from addr.
REQ-017 irq_ack  in  1  CPU interrupt acknowledge pulse.
REQ-018 irqn  out  N  active-low interrupt request per channel.

Function
REQ-019 sig SHALL be registered every clk (sig_l); edge detection SHALL not depend on cen.
REQ-020 Edge channel: event = POL ? sig & ~sig_l : ~sig & sig_l; pending SHALL set on the clk edge after the event cycle.
REQ-021 Level channel: pending SHALL equal registered active level each cycle; clear writes and irq_ack SHALL have no effect.
REQ-022 irqn[i] SHALL equal ~(pending[i] & mask[i]), no added latency; masked events SHALL still set pending.
REQ-023 Register map: addr 0 write mask, read mask; addr 1 write-1-to-clear pending, read pending; addr 2 write-1-to-set pending (edge channels only), read overrun; addr 3 read {8-N zeros, sig_l}, writes ignored.
REQ-024 Bits din[7:N] SHALL be ignored; dout[7:N] SHALL read 0.
REQ-025 irq_ack SHALL clear pending[i] for every i with AUTOCLR[i] & pending[i] & mask[i].
REQ-026 Simultaneous set (event or force) and clear (write or ack) in one cycle: set SHALL win.
REQ-027 pause high SHALL suppress events on PAUSE_CH; an edge occurring during pause SHALL be lost, not deferred; pending already set SHALL remain.
REQ-028 Writes without cen SHALL have no effect; a write held over several cen pulses SHALL act once per cen.

Reset
REQ-029 Under rst: pending=0, overrun=0, mask=MASK_RST, sig_l<=sig (no spurious edge on release); irqn all high.
REQ-030 rst mid-pending SHALL drop pending and irqn in the same clk edge; irq_ack and writes during rst SHALL be ignored.

Configuration
REQ-031 Macro JTDD_IRQ_OVERRUN_EN defined: an edge event on a channel already pending SHALL set overrun[i]; overrun[i] SHALL clear with the addr-1 write-1-to-clear of that bit (set wins).
REQ-032 Macro undefined: no overrun storage; addr 2 read SHALL return 0.

Structure
REQ-033 Package jtdd_irq_pkg SHALL hold register-address constants (MASK, CLR, SET, RAW) and the max-channel constant 8.
REQ-034 Per-channel logic (edge detect, pending, overrun) SHALL be one sub-module jtdd_irq_chan, instantiated N times via generate.

Verification
REQ-035 N=3, default params: sig[0] 0->1 -> pending[0]=1 and irqn[0]=0 one clk later; addr1 write 8'h01 with cen -> irqn[0]=1.
REQ-036 Mask write 8'h06, sig[0] rises -> irqn[0] stays 1, addr1 read = 8'h01; mask write 8'h07 -> irqn[0]=0 immediately.
REQ-037 sig[1] rises in same cycle as addr1 write 8'h02 while pending[1]=1 -> pending[1] remains 1.
REQ-038 pause=1, sig[2] rises -> pending[2]=0; pause=0 with sig[2] held high -> still 0 (event lost).
REQ-039 JTDD_IRQ_OVERRUN_EN, pending[0]=1, second sig[0] edge -> addr2 read = 8'h01; addr1 write 8'h01 -> addr2 reads 8'h00; same stimulus without macro -> addr2 reads 8'h00.
REQ-040 sig=3'b111 held through rst release -> no pending set; AUTOCLR=3'b001, pending[0]=1, irq_ack pulse -> irqn[0]=1 next clk.

Source files
------------

// File: rtl/jtdd_irq_pkg.sv
// Shared constants for the jtdd interrupt controller: register addresses and channel limit.
// Optional overrun tracking is enabled by defining JTDD_IRQ_OVERRUN_EN.
package jtdd_irq_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    REG_MASK = 2'd0,
    REG_CLR  = 2'd1,
    REG_SET  = 2'd2,
    REG_RAW  = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/jtdd_irqctl_if.sv
// CPU-side register bus of the interrupt controller, including the acknowledge pulse.
interface jtdd_irqctl_if;

  logic       cen;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_ack;

  modport master (output cen, cs, we, addr, din, irq_ack, input dout);
  modport slave  (input cen, cs, we, addr, din, irq_ack, output dout);

endinterface

// File: rtl/jtdd_irq_chan.sv
// One interrupt channel: input registration, edge/level detection, pending and overrun flags.
// Overrun storage exists only when JTDD_IRQ_OVERRUN_EN is defined.
module jtdd_irq_chan #(
  parameter bit EDGE     = 1'b1,
  parameter bit POL      = 1'b1,
  parameter bit AUTOCLR  = 1'b0,
  parameter bit PAUSABLE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic pause,
  input  logic mask,
  input  logic clr,
  input  logic set,
  input  logic ack,
  output logic pending,
  output logic overrun,
  output logic sig_l
);

  logic sig_l_q, sig_l_d;
  logic pending_q, pending_d;
  logic active_now, active_prev, gate, ev, set_any, clr_any;

  always_comb begin
    active_now  = POL ? sig : ~sig;
    active_prev = POL ? sig_l_q : ~sig_l_q;
    gate        = PAUSABLE & pause;
    ev          = EDGE & active_now & ~active_prev & ~gate;
    set_any     = ev | set;
    clr_any     = clr | (ack & AUTOCLR & pending_q & mask);
    sig_l_d     = sig;
    // Set beats clear; a level channel just tracks the registered active level.
    if (EDGE) pending_d = set_any | (pending_q & ~clr_any);
    else      pending_d = active_now & (pending_q | ~gate);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      sig_l_q   <= sig;   // tracking sig through reset avoids a false edge on release
    end else begin
      pending_q <= pending_d;
      sig_l_q   <= sig_l_d;
    end
  end

`ifdef JTDD_IRQ_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb overrun_d = (ev & pending_q) | (overrun_q & ~clr);

  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign pending = pending_q;
  assign sig_l   = sig_l_q;

endmodule

// File: rtl/jtdd_irqctl.sv
// Interrupt controller top: mask register, register read mux and N channel instances.
// Define JTDD_IRQ_OVERRUN_EN to make addr 2 read per-channel overrun flags.
module jtdd_irqctl
  import jtdd_irq_pkg::*;
#(
  parameter int           N        = 3,
  parameter logic [N-1:0] EDGE     = {N{1'b1}},
  parameter logic [N-1:0] POL      = {N{1'b1}},
  parameter logic [N-1:0] MASK_RST = {N{1'b1}},
  parameter logic [N-1:0] AUTOCLR  = {N{1'b0}},
  parameter int           PAUSE_CH = N-1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sig,
  input  logic           pause,
  jtdd_irqctl_if.slave   bus,
  output logic [N-1:0]   irqn
);

  logic [N-1:0]      mask_q, mask_d;
  logic [N-1:0]      clr_vec, set_vec, pending, overrun, sig_l;
  logic              wr;
  logic [MAX_CH-1:0] rd_bits;
  logic              unused_din;

  assign unused_din = ^bus.din;

  always_comb begin
    wr      = bus.cs & bus.we & bus.cen;
    mask_d  = mask_q;
    clr_vec = '0;
    set_vec = '0;
    if (wr && bus.addr == REG_MASK) mask_d  = bus.din[N-1:0];
    if (wr && bus.addr == REG_CLR)  clr_vec = bus.din[N-1:0];
    if (wr && bus.addr == REG_SET)  set_vec = bus.din[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= MASK_RST;
    else     mask_q <= mask_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    jtdd_irq_chan #(
      .EDGE    (EDGE[i]),
      .POL     (POL[i]),
      .AUTOCLR (AUTOCLR[i]),
      .PAUSABLE(i == PAUSE_CH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .sig    (sig[i]),
      .pause  (pause),
      .mask   (mask_q[i]),
      .clr    (clr_vec[i]),
      .set    (set_vec[i]),
      .ack    (bus.irq_ack),
      .pending(pending[i]),
      .overrun(overrun[i]),
      .sig_l  (sig_l[i])
    );
  end

  // NOTE: every path assigns rd_bits from a default, so no latch is inferred.
  always_comb begin
    rd_bits = '0;
    case (bus.addr)
      REG_MASK: rd_bits[N-1:0] = mask_q;
      REG_CLR:  rd_bits[N-1:0] = pending;
      REG_SET:  rd_bits[N-1:0] = overrun;
      REG_RAW:  rd_bits[N-1:0] = sig_l;
      default:  rd_bits        = '0;
    endcase
    bus.dout = rd_bits;
  end

  assign irqn = ~(pending & mask_q);

endmodule

// File: tb/tb_jtdd_irqctl.sv
// Self-checking bench: two controller configurations driven in lockstep against a behavioural model.
// Honours JTDD_IRQ_OVERRUN_EN the same way the design does.
module tb_jtdd_irqctl;
  import jtdd_irq_pkg::*;

`ifdef JTDD_IRQ_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  localparam logic [2:0] P_EDGE [2] = '{3'b111, 3'b011};
  localparam logic [2:0] P_POL  [2] = '{3'b111, 3'b101};
  localparam logic [2:0] P_MRST [2] = '{3'b111, 3'b011};
  localparam logic [2:0] P_ACLR [2] = '{3'b000, 3'b001};
  localparam int         P_PCH  [2] = '{2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sig;
  logic       pause;
  logic       cen, cs, we, irq_ack;
  logic [1:0] addr;
  logic [7:0] din;
  logic [2:0] irqn0, irqn1;

  int checks = 0;
  int errors = 0;

  logic [2:0] m_pend [2];
  logic [2:0] m_ovr  [2];
  logic [2:0] m_mask [2];
  logic [2:0] m_sl   [2];

  jtdd_irqctl_if bus0 ();
  jtdd_irqctl_if bus1 ();

  assign bus0.cen = cen;  assign bus0.cs = cs;  assign bus0.we = we;
  assign bus0.addr = addr; assign bus0.din = din; assign bus0.irq_ack = irq_ack;
  assign bus1.cen = cen;  assign bus1.cs = cs;  assign bus1.we = we;
  assign bus1.addr = addr; assign bus1.din = din; assign bus1.irq_ack = irq_ack;

  always #5 clk = ~clk;

  jtdd_irqctl #(.N(3)) u_dut0 (
    .clk(clk), .rst(rst), .sig(sig), .pause(pause), .bus(bus0), .irqn(irqn0)
  );

  jtdd_irqctl #(
    .N(3), .EDGE(3'b011), .POL(3'b101), .MASK_RST(3'b011), .AUTOCLR(3'b001), .PAUSE_CH(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .sig(sig), .pause(pause), .bus(bus1), .irqn(irqn1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge of the rules to the model of controller k.
  task automatic model_step(input int k);
    logic [2:0] np, no;
    bit wr;
    if (rst) begin
      m_pend[k] = '0;
      m_ovr[k]  = '0;
      m_mask[k] = P_MRST[k];
      m_sl[k]   = sig;
      return;
    end
    wr = cs && we && cen;
    np = m_pend[k];
    no = m_ovr[k];
    for (int i = 0; i < 3; i++) begin
      bit act_now, act_prev, paused, hit, clr_b, frc, ackc;
      act_now  = P_POL[k][i] ? sig[i] : !sig[i];
      act_prev = P_POL[k][i] ? m_sl[k][i] : !m_sl[k][i];
      paused   = pause && (i == P_PCH[k]);
      hit      = act_now && !act_prev && !paused;
      clr_b    = wr && addr == 2'd1 && din[i];
      frc      = wr && addr == 2'd2 && din[i];
      ackc     = irq_ack && P_ACLR[k][i] && m_pend[k][i] && m_mask[k][i];
      if (P_EDGE[k][i]) begin
        if (hit || frc)        np[i] = 1'b1;
        else if (clr_b || ackc) np[i] = 1'b0;
        if (OVR_EN) begin
          if (hit && m_pend[k][i]) no[i] = 1'b1;
          else if (clr_b)          no[i] = 1'b0;
        end
      end else begin
        np[i] = act_now && (m_pend[k][i] || !paused);
      end
    end
    if (wr && addr == 2'd0) m_mask[k] = din[2:0];
    m_pend[k] = np;
    m_ovr[k]  = no;
    m_sl[k]   = sig;
  endtask

  function automatic logic [7:0] exp_dout(input int k);
    case (addr)
      2'd0:    return {5'b0, m_mask[k]};
      2'd1:    return {5'b0, m_pend[k]};
      2'd2:    return {5'b0, m_ovr[k]};
      default: return {5'b0, m_sl[k]};
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    check("dut0 irqn", {5'b0, irqn0}, {5'b0, ~(m_pend[0] & m_mask[0])});
    check("dut1 irqn", {5'b0, irqn1}, {5'b0, ~(m_pend[1] & m_mask[1])});
    check($sformatf("dut0 dout a%0d", addr), bus0.dout, exp_dout(0));
    check($sformatf("dut1 dout a%0d", addr), bus1.dout, exp_dout(1));
  endtask

  task automatic idle();
    cs = 1'b0; we = 1'b0; cen = 1'b1; din = 8'h00; irq_ack = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; cen = 1'b1; addr = a; din = d;
    cyc();
    idle();
  endtask

  task automatic peek(input logic [1:0] a);
    addr = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; sig = 3'b111; pause = 1'b0; addr = 2'd0;
    idle();
    repeat (3) cyc();
    check("reset irqn", {5'b0, irqn0}, 8'h07);
    peek(0);
    check("reset mask dut0", bus0.dout, 8'h07);
    check("reset mask dut1", bus1.dout, 8'h03);

    rst = 1'b0;
    cyc(); cyc();
    peek(1);
    check("no edge on release", bus0.dout, 8'h00);

    sig = 3'b000; cyc();
    sig[0] = 1'b1; cyc();
    check("edge sets irqn0", {7'b0, irqn0[0]}, 8'h00);
    wr_reg(1, 8'h01);
    check("w1c clears irqn0", {7'b0, irqn0[0]}, 8'h01);

    wr_reg(0, 8'h06);
    sig[0] = 1'b0; cyc();
    sig[0] = 1'b1; cyc();
    check("masked irqn0", {7'b0, irqn0[0]}, 8'h01);
    peek(1);
    check("masked pending", bus0.dout, 8'h01);
    wr_reg(0, 8'h07);
    check("unmask irqn0", {7'b0, irqn0[0]}, 8'h00);

    sig[1] = 1'b1; cyc();
    sig[1] = 1'b0; cyc();
    sig[1] = 1'b1; cs = 1'b1; we = 1'b1; cen = 1'b1; addr = 2'd1; din = 8'h02;
    cyc();
    idle();
    peek(1);
    check("set beats clear", bus0.dout, 8'h03);

    pause = 1'b1; sig[2] = 1'b1; cyc();
    peek(1);
    check("paused edge", bus0.dout, 8'h03);
    pause = 1'b0; cyc(); cyc();
    peek(1);
    check("paused edge lost", bus0.dout, 8'h03);

    cs = 1'b1; we = 1'b1; cen = 1'b0; addr = 2'd0; din = 8'h00;
    cyc();
    idle();
    peek(0);
    check("write without cen", bus0.dout, 8'h07);

    sig[0] = 1'b0; cyc();
    sig[0] = 1'b1; cyc();
    peek(2);
    check("overrun set", bus0.dout, OVR_EN ? 8'h01 : 8'h00);
    wr_reg(1, 8'h01);
    peek(2);
    check("overrun cleared", bus0.dout, 8'h00);

    sig[0] = 1'b0; cyc();
    sig[0] = 1'b1; cyc();
    irq_ack = 1'b1; cyc();
    irq_ack = 1'b0;
    check("autoclr ack dut1", {7'b0, irqn1[0]}, 8'h01);
    check("no autoclr dut0", {7'b0, irqn0[0]}, 8'h00);

    cs = 1'b1; we = 1'b1; addr = 2'd2; din = 8'h02;
    for (int i = 0; i < 6; i++) begin
      cen = i[0];
      cyc();
    end
    idle();

    rst = 1'b1; irq_ack = 1'b1; cs = 1'b1; we = 1'b1; addr = 2'd0; din = 8'h00;
    cyc();
    check("rst drops irqn0", {5'b0, irqn0}, 8'h07);
    check("rst drops irqn1", {5'b0, irqn1}, 8'h07);
    rst = 1'b0;
    idle();
    cyc();
    peek(0);
    check("write in rst ignored", bus0.dout, 8'h07);

    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      sig     = 3'($urandom);
      pause   = ($urandom_range(0, 3) == 0);
      cs      = 1'($urandom);
      we      = 1'($urandom);
      cen     = 1'($urandom);
      addr    = 2'($urandom);
      din     = 8'($urandom);
      irq_ack = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
